// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed seven-segment scanner with a shadow/active glyph buffer swapped at frame boundaries.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_segment_scan_controller #(
    parameter int N_DIGITS     = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [$clog2(N_DIGITS)-1:0] wr_idx,
    input  logic [4:0]                  wr_data,
    input  logic                        commit,
    output logic                        commit_pending,
    output logic [6:0]                  abcdefg,
    output logic [N_DIGITS-1:0]         digit_en,
    output logic                        frame_start
);

    localparam int IDX_W   = $clog2(N_DIGITS);
    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [4:0] GLYPH_BLANK = 5'h10;

    typedef enum logic {
        ST_SHOW,
        ST_BLANK
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [4:0]         shadow [N_DIGITS];
    logic [4:0]         active [N_DIGITS];
    logic [4:0]         view   [N_DIGITS];
    logic [N_DIGITS-1:0] lz_mask;
    logic               boundary;
    logic               swap;
    logic               wr_ok;
    logic [4:0]         code_nxt;
    logic [6:0]         seg_nxt;
    logic [N_DIGITS-1:0] en_nxt;
    logic               pending_nxt;

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] seg;
        seg = 7'b0000000;
        if (!code[4]) begin
            case (code[3:0])
                4'h0: seg = 7'b1111110;
                4'h1: seg = 7'b0110000;
                4'h2: seg = 7'b1101101;
                4'h3: seg = 7'b1111001;
                4'h4: seg = 7'b0110011;
                4'h5: seg = 7'b1011011;
                4'h6: seg = 7'b1011111;
                4'h7: seg = 7'b1110000;
                4'h8: seg = 7'b1111111;
                4'h9: seg = 7'b1111011;
                4'hA: seg = 7'b1110111;
                4'hB: seg = 7'b0011111;
                4'hC: seg = 7'b1001110;
                4'hD: seg = 7'b0111101;
                4'hE: seg = 7'b1001111;
                default: seg = 7'b1000111;
            endcase
        end
        return seg;
    endfunction

    // Scan sequencing: each phase counts 0..LEN-1, then hands over.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            ST_SHOW: begin
                if (cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end
        endcase
    end

    // The frame boundary is the register edge that enters SHOW of digit 0.
    always_comb begin
        boundary = (state == ST_BLANK) && (state_nxt == ST_SHOW) && (idx_nxt == '0);
        swap     = boundary && commit_pending;
        wr_ok    = wr_en && (int'(wr_idx) < N_DIGITS);
        for (int i = 0; i < N_DIGITS; i++) begin
            view[i] = swap ? shadow[i] : active[i];
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic lz_run;
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (view[i] == 5'h00);
            lz_mask[i] = lz_run;
        end
    end
`else
    always_comb begin
        lz_mask = '0;
    end
`endif

    // Outputs are precomputed from the next state so the registered pins line up with the FSM.
    always_comb begin
        code_nxt = lz_mask[idx_nxt] ? GLYPH_BLANK : view[idx_nxt];
        seg_nxt  = (state_nxt == ST_SHOW) ? decode(code_nxt) : 7'b0000000;
        en_nxt   = (state_nxt == ST_SHOW) ? (N_DIGITS'(1) << idx_nxt) : '0;
        pending_nxt = commit_pending;
        if (swap) begin
            pending_nxt = 1'b0;
        end
        if (commit) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_BLANK;
            idx            <= IDX_W'(N_DIGITS - 1);
            cnt            <= '0;
            commit_pending <= 1'b0;
            abcdefg        <= 7'b0000000;
            digit_en       <= '0;
            frame_start    <= 1'b0;
            // NOTE: the glyph buffers are reset on purpose so a reset always blanks the display.
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow[i] <= GLYPH_BLANK;
                active[i] <= GLYPH_BLANK;
            end
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            cnt            <= cnt_nxt;
            commit_pending <= pending_nxt;
            abcdefg        <= seg_nxt;
            digit_en       <= en_nxt;
            frame_start    <= boundary;
            for (int i = 0; i < N_DIGITS; i++) begin
                active[i] <= view[i];
            end
            // Swap reads the old shadow, so a same-edge write lands only in shadow.
            if (wr_ok) begin
                shadow[wr_idx] <= wr_data;
            end
        end
    end

endmodule
